// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ISA constants and fetch-state encoding for the front end
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DROP, HOLD} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, single-outstanding imem fetch and decode-stage instruction register
module instr_fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      dec_op,
  output logic [2:0]      dec_funct3,
  output logic            dec_funct7,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
);
  fetch_state_e state;
  logic [XLEN-1:0] pc_q, req_pc, tgt;
  assign tgt = redirect_target & ~XLEN'(3);
  assign imem_req_valid = state == FETCH;
  assign imem_req_addr = pc_q;
  assign dec_valid = state == HOLD;
  assign dec_op = dec_instr[6:0];
  assign dec_funct3 = dec_instr[14:12];
  assign dec_funct7 = dec_instr[30];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q <= RESET_PC;
      req_pc <= RESET_PC;
      dec_instr <= NOP_INSTR;
      dec_pc <= '0;
    end else begin
      if (redirect) pc_q <= tgt;
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (imem_req_ready) begin
          state <= redirect ? DROP : WAIT;
          req_pc <= pc_q;
        end
        WAIT: if (redirect) state <= imem_rsp_valid ? FETCH : DROP;
          else if (imem_rsp_valid) begin
            state <= HOLD;
            dec_instr <= imem_rsp_data;
            dec_pc <= req_pc;
            pc_q <= req_pc + XLEN'(4);
          end
        DROP: if (imem_rsp_valid) state <= FETCH;
        HOLD: if (redirect || dec_ready) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + random stimulus against a transaction-level fetch model
module tb_instr_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, dec_valid, dec_ready = 0, redirect = 0, dec_funct7;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, dec_instr, dec_pc, redirect_target = 0;
  logic [6:0] dec_op;
  logic [2:0] dec_funct3;
  int total = 0, passed = 0;
  int rdy_pct = 100, dr_pct = 100, redir_pct = 0, stray_pct = 0, rst_pm = 0, lat_min = 0, lat_max = 0;
  bit os_rst, os_redir, os_stray, busy;
  logic [31:0] os_tgt, baddr;
  int cnt;
  logic [31:0] acc_log[$];

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
    .redirect(redirect), .redirect_target(redirect_target));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h8:   return 32'h4000_5033;
      32'hC:   return 32'h00A3_0333;
      32'h10:  return 32'h0000_0063;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_7013;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
  endtask

  // One clock: imem bookkeeping from pre-edge values, then drive next inputs, return at negedge
  task automatic step();
    bit acc, rspd, r;
    logic [31:0] a;
    r = rst;
    acc = imem_req_valid && imem_req_ready && !rst;
    rspd = imem_rsp_valid && busy;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    if (r) busy = 0;
    else begin
      if (rspd) busy = 0;
      if (acc) begin
        busy = 1; baddr = a; cnt = $urandom_range(lat_max, lat_min); acc_log.push_back(a);
      end else if (busy && cnt > 0) cnt--;
    end
    rst = os_rst || ($urandom_range(999) < rst_pm);
    redirect = os_redir || ($urandom_range(99) < redir_pct);
    redirect_target = os_redir ? os_tgt : $urandom;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    dec_ready = $urandom_range(99) < dr_pct;
    imem_rsp_valid = busy ? cnt == 0 : (os_stray || $urandom_range(99) < stray_pct);
    imem_rsp_data = busy ? mem(baddr) : $urandom;
    os_rst = 0; os_redir = 0; os_stray = 0;
    @(negedge clk);
  endtask

  task automatic wait_dec_pc(input logic [31:0] a, input int lim);
    int n = 0;
    while (!(dec_valid && dec_pc == a) && n < lim) begin step(); n++; end
    chk("wait_dec_pc", {dec_valid, dec_pc}, {1'b1, a});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h13);
    chk("rst_dec_pc", dec_pc, 0);
  endtask

  // Transaction-level reference: which fetch is outstanding / wrong-path, what decode holds
  initial begin
    bit mv = 0, started, outs, wrong, have, e_req, acc, rsp;
    logic [31:0] exp_pc, req_a, hold_pc, hold_instr;
    forever begin
      @(negedge clk);
      e_req = started && !outs && !have;
      if (mv) begin
        chk("m_req_valid", imem_req_valid, e_req);
        if (!outs && !have) chk("m_req_addr", imem_req_addr, exp_pc);
        chk("m_dec_valid", dec_valid, have);
        chk("m_dec_instr", dec_instr, hold_instr);
        chk("m_dec_pc", dec_pc, hold_pc);
        chk("m_dec_op", dec_op, hold_instr[6:0]);
        chk("m_dec_funct3", dec_funct3, hold_instr[14:12]);
        chk("m_dec_funct7", dec_funct7, hold_instr[30]);
      end
      if (rst) begin
        mv = 1; started = 0; outs = 0; wrong = 0; have = 0;
        exp_pc = 0; req_a = 0; hold_pc = 0; hold_instr = 32'h13;
      end else if (mv) begin
        acc = e_req && imem_req_ready;
        rsp = outs && imem_rsp_valid;
        if (redirect) begin
          exp_pc = redirect_target & ~32'h3;
          if (acc) begin outs = 1; wrong = 1; end
          else if (rsp) outs = 0;
          else if (outs) wrong = 1;
          have = 0;
        end else begin
          if (have && dec_ready) have = 0;
          if (acc) begin outs = 1; wrong = 0; req_a = exp_pc; end
          if (rsp) begin
            outs = 0;
            if (!wrong) begin have = 1; hold_pc = req_a; hold_instr = mem(req_a); exp_pc = req_a + 4; end
          end
        end
        started = 1;
      end
    end
  end

  initial begin
    bit bad;
    int n;
    @(negedge clk);
    os_rst = 1; step();
    step();
    chk_reset_outputs();
    step();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    wait_dec_pc(32'h8, 30);
    chk("slice_op", dec_op, 7'h33);
    chk("slice_funct3", dec_funct3, 3'd5);
    chk("slice_funct7", dec_funct7, 1);
    chk("acc_count", acc_log.size(), 3);
    for (int i = 0; i < 3 && i < acc_log.size(); i++) chk("acc_addr", acc_log[i], 32'(i * 4));
    dr_pct = 0;
    wait_dec_pc(32'hC, 30);
    for (int i = 0; i < 5; i++) begin
      chk("stall_dec_valid", dec_valid, 1);
      chk("stall_dec_instr", dec_instr, 32'h00A3_0333);
      chk("stall_no_req", imem_req_valid, 0);
      step();
    end
    dr_pct = 100;
    step();
    step();
    chk("after_consume_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h10});
    dr_pct = 0;
    wait_dec_pc(32'h10, 30);
    chk("branch_word", dec_instr, 32'h0000_0063);
    dr_pct = 100; os_redir = 1; os_tgt = 32'h40;
    step();
    step();
    chk("hold_redirect_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h40});
    dr_pct = 0;
    wait_dec_pc(32'h40, 30);
    os_redir = 1; os_tgt = 32'h83;
    step();
    step();
    chk("squash_dec_valid", dec_valid, 0);
    chk("squash_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h80});
    dr_pct = 100; lat_min = 3; lat_max = 3;
    step();
    chk("wait_no_req", imem_req_valid, 0);
    os_redir = 1; os_tgt = 32'h102; rdy_pct = 0;
    step();
    step();
    bad = 0; n = 0;
    while (!imem_req_valid && n < 12) begin bad |= dec_valid; step(); n++; end
    chk("drop_next_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
    chk("drop_never_decoded", bad, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req_held", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
    end
    os_redir = 1; os_tgt = 32'hFFFF_FFFE;
    step();
    rdy_pct = 100; lat_min = 0; lat_max = 0;
    step();
    chk("wrap_first", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFC});
    step();
    n = 0;
    while (!(imem_req_valid && imem_req_addr != 32'hFFFF_FFFC) && n < 12) begin step(); n++; end
    chk("wrap_second", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    lat_min = 3; lat_max = 3;
    step();
    chk("t6_in_wait", imem_req_valid, 0);
    os_rst = 1;
    step();
    os_stray = 1;
    step();
    chk_reset_outputs();
    lat_min = 0; lat_max = 0;
    step();
    chk("restart_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    chk("stray_ignored", dec_valid, 0);
    wait_dec_pc(32'h0, 20);
    chk("restart_instr", dec_instr, mem(32'h0));
    rdy_pct = 60; dr_pct = 60; redir_pct = 8; stray_pct = 5; rst_pm = 5; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 4000; i++) step();
    rst_pm = 0; redir_pct = 0;
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
